// File: rtl/sdram_arbiter_n.sv
// sdram_arbiter_n
//   N-client arbiter in front of the 16-bit SDRAM bridge. One transaction is
//   outstanding at a time. Each transaction runs IDLE -> ISSUE -> RELEASE.
//   Arbitration is fixed priority (ARB_MODE=0, lowest index wins) or
//   round-robin (ARB_MODE=1).
//
// Optional feature: define ARB_TIMEOUT_EN to enable the ack-timeout watchdog.
//   The watchdog aborts an ISSUE after TIMEOUT_CYCLES cycles without an
//   acknowledge and pulses cli_err. Without the macro, cli_err is tied to 0.
//
// Ports
//   clk, reset_reset_n   clock, synchronous active-low reset
//   cli_req/we           per-client request (held until ack) and write flag
//   cli_addr/be/wrdata   packed per-client address, byte enable, write data
//   cli_ack / cli_err    one-cycle completion / timeout pulse to the owner
//   cli_rddata           registered read data, valid with cli_ack
//   grant, busy          one-hot current owner, transaction in flight
//   bridge_*             SDRAM bridge master side (strobes held until ack)
module sdram_arbiter_n #(
  parameter int unsigned NUM_CLIENTS    = 3,
  parameter int unsigned ADDR_W         = 25,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned BE_W           = 2,
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset_reset_n,
  input  logic [NUM_CLIENTS-1:0]        cli_req,
  input  logic [NUM_CLIENTS-1:0]        cli_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
  input  logic [NUM_CLIENTS*BE_W-1:0]   cli_be,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_wrdata,
  output logic [NUM_CLIENTS-1:0]        cli_ack,
  output logic [DATA_W-1:0]             cli_rddata,
  output logic [NUM_CLIENTS-1:0]        cli_err,
  output logic [NUM_CLIENTS-1:0]        grant,
  output logic                          busy,
  output logic [ADDR_W-1:0]             bridge_address,
  output logic [BE_W-1:0]               bridge_byte_enable,
  output logic                          bridge_read,
  output logic                          bridge_write,
  output logic [DATA_W-1:0]             bridge_write_data,
  input  logic                          bridge_acknowledge,
  input  logic [DATA_W-1:0]             bridge_read_data
);

  localparam int unsigned IDX_W = $clog2(NUM_CLIENTS);

  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || BE_W * 8 != DATA_W ||
      ARB_MODE > 1 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("sdram_arbiter_n: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE} state_e;

  state_e                  state_q, state_d;
  logic [NUM_CLIENTS-1:0]  grant_q, grant_d;
  logic                    busy_q, busy_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [NUM_CLIENTS-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]       rddata_q, rddata_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;

  logic [IDX_W-1:0]        win_idx;
  logic                    win_vld;
  logic [IDX_W:0]          cand;
  logic                    tmo;

  // Winner search. In round-robin mode the scan starts at rr_ptr_q and wraps
  // modulo NUM_CLIENTS; fixed priority scans upward from index 0.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      if (ARB_MODE == 0) begin
        cand = (IDX_W+1)'(k);
      end else begin
        cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(NUM_CLIENTS)) cand = cand - (IDX_W+1)'(NUM_CLIENTS);
      end
      if (!win_vld && cli_req[cand[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_reset_n) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (win_vld) state_d = S_ISSUE;
      S_ISSUE:   if (bridge_acknowledge || tmo) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic. Every output is registered.
  // An acknowledge takes priority over a coincident timeout.
  always_comb begin
    grant_d  = grant_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    ack_d    = '0;
    rddata_d = rddata_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = NUM_CLIENTS'(1) << win_idx;
          busy_d  = 1'b1;
          addr_d  = cli_addr[win_idx*ADDR_W +: ADDR_W];
          be_d    = cli_be[win_idx*BE_W +: BE_W];
          wdata_d = cli_wrdata[win_idx*DATA_W +: DATA_W];
          rd_d    = ~cli_we[win_idx];
          wr_d    = cli_we[win_idx];
          if (ARB_MODE == 1) begin
            rr_ptr_d = (win_idx == IDX_W'(NUM_CLIENTS-1)) ? '0 : win_idx + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (bridge_acknowledge) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (rd_q) rddata_d = bridge_read_data;
          ack_d   = grant_q;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (tmo) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      S_RELEASE: begin
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_reset_n) begin
      grant_q  <= '0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack_q    <= '0;
      rddata_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ack_q    <= ack_d;
      rddata_q <= rddata_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [NUM_CLIENTS-1:0] err_q, err_d;

  // The count is the number of ISSUE cycles already completed, so the abort
  // lands on the edge that ends the TIMEOUT_CYCLES-th ISSUE cycle.
  assign tmo = (state_q == S_ISSUE) && !bridge_acknowledge &&
               (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Holding the count at zero in IDLE has the same effect as clearing it on
  // entry to ISSUE.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = '0;
    if (state_q == S_IDLE)       tmo_cnt_d = '0;
    else if (state_q == S_ISSUE) tmo_cnt_d = tmo_cnt_q + 1'b1;
    if (tmo) err_d = grant_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_reset_n) begin
      tmo_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign cli_err = err_q;
`else
  assign tmo     = 1'b0;
  assign cli_err = '0;
`endif

  assign cli_ack            = ack_q;
  assign cli_rddata         = rddata_q;
  assign grant              = grant_q;
  assign busy               = busy_q;
  assign bridge_address     = addr_q;
  assign bridge_byte_enable = be_q;
  assign bridge_read        = rd_q;
  assign bridge_write       = wr_q;
  assign bridge_write_data  = wdata_q;

endmodule

// File: tb/tb_sdram_arbiter_n.sv
// Bench for sdram_arbiter_n.
// Two instances are built: index 0 uses fixed priority and index 1 uses
// round-robin. A stimulus process queues the expected transactions. A
// negedge monitor checks each strobe assertion and each ack or err pulse
// against the head of that queue.
`timescale 1ns/1ps
module tb_sdram_arbiter_n;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic             rst_n;
  logic [N-1:0]     req     [2];
  logic [N-1:0]     we      [2];
  logic [N*AW-1:0]  addr    [2];
  logic [N*BW-1:0]  be      [2];
  logic [N*DW-1:0]  wd      [2];
  logic [N-1:0]     ack     [2];
  logic [N-1:0]     err     [2];
  logic [N-1:0]     grant   [2];
  logic [DW-1:0]    rddata  [2];
  logic             busy    [2];
  logic [AW-1:0]    b_addr  [2];
  logic [BW-1:0]    b_be    [2];
  logic             b_rd    [2];
  logic             b_wr    [2];
  logic [DW-1:0]    b_wd    [2];
  logic             b_ack   [2];
  logic [DW-1:0]    b_rdata [2];
  logic             resp_ack[2];
  logic             man_ack [2];
  logic             resp_en [2];
  int unsigned      lat     [2];
  logic [DW-1:0]    rdval   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sdram_arbiter_n #(
      .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW),
      .ARB_MODE(g), .TIMEOUT_CYCLES(8)
    ) u_dut (
      .clk(clk), .reset_reset_n(rst_n),
      .cli_req(req[g]), .cli_we(we[g]), .cli_addr(addr[g]), .cli_be(be[g]),
      .cli_wrdata(wd[g]), .cli_ack(ack[g]), .cli_rddata(rddata[g]),
      .cli_err(err[g]), .grant(grant[g]), .busy(busy[g]),
      .bridge_address(b_addr[g]), .bridge_byte_enable(b_be[g]),
      .bridge_read(b_rd[g]), .bridge_write(b_wr[g]),
      .bridge_write_data(b_wd[g]), .bridge_acknowledge(b_ack[g]),
      .bridge_read_data(b_rdata[g])
    );
  end

  always_comb begin
    for (int d = 0; d < 2; d++) b_ack[d] = resp_ack[d] | man_ack[d];
  end

  // Bridge model: acknowledges after lat[d] strobe cycles.
  initial begin
    int unsigned rcnt [2];
    for (int d = 0; d < 2; d++) begin
      resp_ack[d] = 1'b0;
      b_rdata[d]  = '0;
      rcnt[d]     = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (resp_ack[d]) begin
          resp_ack[d] = 1'b0;
          rcnt[d]     = 0;
        end else if ((b_rd[d] | b_wr[d]) && resp_en[d]) begin
          rcnt[d]++;
          if (rcnt[d] >= lat[d]) begin
            resp_ack[d] = 1'b1;
            b_rdata[d]  = rdval[d];
          end
        end else begin
          rcnt[d] = 0;
        end
      end
    end
  end

  typedef struct {
    int unsigned   inst;
    logic [N-1:0]  gnt;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    logic          we;
    logic [DW-1:0] rd;
    int unsigned   len;
    logic          is_err;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned acks_seen [2];
  int unsigned strobe_len[2];
  logic        prev_stb  [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input int unsigned d, input logic [N-1:0] gnt, input logic [AW-1:0] a,
                      input logic [BW-1:0] b, input logic [DW-1:0] w, input logic wen,
                      input logic [DW-1:0] rd, input int unsigned len, input logic is_err);
    exp_t e;
    e.inst = d; e.gnt = gnt; e.a = a; e.be = b; e.wd = w; e.we = wen;
    e.rd = rd; e.len = len; e.is_err = is_err;
    sbq.push_back(e);
  endtask

  task automatic set_cli(input int d, input int i, input logic wen, input logic [AW-1:0] a,
                         input logic [BW-1:0] b, input logic [DW-1:0] w);
    we[d][i]              = wen;
    addr[d][i*AW +: AW]   = a;
    be[d][i*BW +: BW]     = b;
    wd[d][i*DW +: DW]     = w;
  endtask

  // Waits for the ack or err pulse and checks its owner. On return the
  // current cycle is the RELEASE cycle.
  task automatic wait_done(input int d, input logic [N-1:0] exp_who);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(posedge clk); #1;
      if ((ack[d] | err[d]) != '0) begin
        seen = 1'b1;
        check("done_owner", ack[d] | err[d], exp_who);
      end
    end
    if (!seen) check("done_wait_expired", 0, 1);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if ((b_rd[d] | b_wr[d]) && !prev_stb[d]) begin
          strobe_len[d] = 1;
          if (sbq.size() == 0 || sbq[0].inst != d) begin
            check("unexpected_issue", 1, 0);
          end else begin
            check("issue_ctl", {grant[d], busy[d], b_rd[d], b_wr[d]},
                  {sbq[0].gnt, 1'b1, ~sbq[0].we, sbq[0].we});
            check("issue_addr", b_addr[d], sbq[0].a);
            check("issue_be", b_be[d], sbq[0].be);
            check("issue_wdata", b_wd[d], sbq[0].wd);
          end
        end else if (b_rd[d] | b_wr[d]) begin
          strobe_len[d]++;
        end
        if ((ack[d] | err[d]) != '0) begin
          acks_seen[d]++;
          if (sbq.size() == 0 || sbq[0].inst != d) begin
            check("unexpected_ack", {ack[d], err[d]}, 0);
          end else begin
            mon_e = sbq.pop_front();
            check("ack_err", {ack[d], err[d]},
                  mon_e.is_err ? {{N{1'b0}}, mon_e.gnt} : {mon_e.gnt, {N{1'b0}}});
            check("rddata", rddata[d], mon_e.rd);
            check("strobe_cycles", strobe_len[d], mon_e.len);
            check("release_idle", {grant[d], busy[d], b_rd[d], b_wr[d]}, 0);
          end
        end
        prev_stb[d] = b_rd[d] | b_wr[d];
      end
    end
  end

  // Stimulus
  initial begin
    int unsigned saved;
    logic        seen;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; we[d] = '0; addr[d] = '0; be[d] = '0; wd[d] = '0;
      man_ack[d] = 1'b0; resp_en[d] = 1'b1; lat[d] = 1; rdval[d] = '0;
      acks_seen[d] = 0; strobe_len[d] = 0; prev_stb[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ctl", {grant[d], busy[d], b_rd[d], b_wr[d], ack[d], err[d]}, 0);
      check("rst_data", {b_addr[d], b_be[d], b_wd[d], rddata[d]}, 0);
    end
    rst_n = 1'b1;

    // Single read by client 1 with a 4-cycle bridge latency
    set_cli(0, 1, 1'b0, 25'h000123, 2'b11, 16'h0000);
    lat[0] = 4; rdval[0] = 16'hBEEF;
    push(0, 3'b010, 25'h000123, 2'b11, 16'h0000, 1'b0, 16'hBEEF, 4, 1'b0);
    req[0][1] = 1'b1;
    wait_done(0, 3'b010);
    req[0][1] = 1'b0;

    // Write by client 2 at the top address; the ack arrives in the first ISSUE cycle
    set_cli(0, 2, 1'b1, 25'h1FFFFFF, 2'b01, 16'h00A5);
    lat[0] = 1; rdval[0] = 16'h1234;
    push(0, 3'b100, 25'h1FFFFFF, 2'b01, 16'h00A5, 1'b1, 16'hBEEF, 1, 1'b0);
    req[0][2] = 1'b1;
    wait_done(0, 3'b100);
    req[0][2] = 1'b0;

    // Fixed priority: client 0 starves the others until it drops its request
    set_cli(0, 0, 1'b0, 25'h10, 2'b11, 16'h0000);
    set_cli(0, 1, 1'b0, 25'h20, 2'b11, 16'h0000);
    set_cli(0, 2, 1'b0, 25'h30, 2'b11, 16'h0000);
    lat[0] = 2; rdval[0] = 16'h0F0F;
    for (int k = 0; k < 3; k++) push(0, 3'b001, 25'h10, 2'b11, 16'h0, 1'b0, 16'h0F0F, 2, 1'b0);
    push(0, 3'b010, 25'h20, 2'b11, 16'h0, 1'b0, 16'h0F0F, 2, 1'b0);
    push(0, 3'b100, 25'h30, 2'b11, 16'h0, 1'b0, 16'h0F0F, 2, 1'b0);
    req[0] = 3'b111;
    for (int k = 0; k < 3; k++) wait_done(0, 3'b001);
    req[0][0] = 1'b0;
    wait_done(0, 3'b010);
    req[0][1] = 1'b0;
    wait_done(0, 3'b100);
    req[0][2] = 1'b0;

    // Reset in the middle of ISSUE, followed by a late acknowledge
    resp_en[0] = 1'b0;
    set_cli(0, 0, 1'b0, 25'h55, 2'b11, 16'h0000);
    push(0, 3'b001, 25'h55, 2'b11, 16'h0, 1'b0, 16'h0, 0, 1'b0);
    req[0][0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      if (b_rd[0]) seen = 1'b1;
    end
    if (!seen) check("strobe_wait_expired", 0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req[0] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_ctl", {grant[0], busy[0], b_rd[0], b_wr[0], ack[0], err[0]}, 0);
    check("midrst_data", {b_addr[0], b_be[0], b_wd[0], rddata[0]}, 0);
    sbq.delete();
    saved = acks_seen[0];
    man_ack[0] = 1'b1;
    @(posedge clk); #1;
    man_ack[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("late_ack_ignored", acks_seen[0], saved);
    check("late_ack_idle", {grant[0], busy[0], b_rd[0], b_wr[0]}, 0);
    resp_en[0] = 1'b1;

    // Round-robin: all clients request continuously; the pointer wraps from 2 to 0
    for (int i = 0; i < 3; i++) set_cli(1, i, 1'b0, AW'(32'h100 + i), 2'b10, 16'h0000);
    lat[1] = 1; rdval[1] = 16'hC0DE;
    push(1, 3'b001, 25'h100, 2'b10, 16'h0, 1'b0, 16'hC0DE, 1, 1'b0);
    push(1, 3'b010, 25'h101, 2'b10, 16'h0, 1'b0, 16'hC0DE, 1, 1'b0);
    push(1, 3'b100, 25'h102, 2'b10, 16'h0, 1'b0, 16'hC0DE, 1, 1'b0);
    push(1, 3'b001, 25'h100, 2'b10, 16'h0, 1'b0, 16'hC0DE, 1, 1'b0);
    req[1] = 3'b111;
    wait_done(1, 3'b001);
    wait_done(1, 3'b010);
    wait_done(1, 3'b100);
    wait_done(1, 3'b001);
    req[1] = '0;

`ifdef ARB_TIMEOUT_EN
    // Watchdog: no acknowledge for 8 ISSUE cycles, then a normal transaction
    resp_en[0] = 1'b0;
    set_cli(0, 2, 1'b0, 25'h77, 2'b11, 16'h0000);
    push(0, 3'b100, 25'h77, 2'b11, 16'h0, 1'b0, 16'h0000, 8, 1'b1);
    req[0][2] = 1'b1;
    wait_done(0, 3'b100);
    req[0][2] = 1'b0;
    resp_en[0] = 1'b1;
    lat[0] = 3; rdval[0] = 16'h7777;
    set_cli(0, 1, 1'b0, 25'h88, 2'b11, 16'h0000);
    push(0, 3'b010, 25'h88, 2'b11, 16'h0, 1'b0, 16'h7777, 3, 1'b0);
    req[0][1] = 1'b1;
    wait_done(0, 3'b010);
    req[0][1] = 1'b0;
`endif

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
